// File: rtl/mtimer_unit_pkg.sv
// Shared definitions for the machine-mode timer: register word offsets,
// CTRL bit positions and the mtimecmp reset constant.
package mtimer_unit_pkg;

  typedef enum logic [2:0] {
    OFS_MTIME_LO    = 3'd0,
    OFS_MTIME_HI    = 3'd1,
    OFS_MTIMECMP_LO = 3'd2,
    OFS_MTIMECMP_HI = 3'd3,
    OFS_CTRL        = 3'd4
  } reg_ofs_e;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_CLR       = 1;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  localparam logic [63:0] CMP_RST_DEFAULT = '1;

  function automatic logic [31:0] lo_word(input logic [63:0] v);
    return v[31:0];
  endfunction

  function automatic logic [31:0] hi_word(input logic [63:0] v);
    return v[63:32];
  endfunction

endpackage

// File: rtl/mtimer_unit_cnt64.sv
// 64-bit mtime counter: clear, split-half bus load and increment with
// carry from the low into the high word.
module mtimer_cnt64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_inc,
  input  logic        i_ld_lo,
  input  logic        i_ld_hi,
  input  logic [31:0] i_ld_data,
  output logic [63:0] o_cnt
);

  logic [63:0] r_cnt;

  // Clear beats a bus load, a bus load beats the increment; a loaded cycle
  // leaves the other half untouched (no carry into it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ld_lo) begin
      r_cnt[31:0] <= i_ld_data;
    end else if (i_ld_hi) begin
      r_cnt[63:32] <= i_ld_data;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 64'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mtimer_unit.sv
// Machine-mode timer peripheral: mtime/mtimecmp on the I/O bus, CTRL
// (EN, CLR), LO-then-HI atomic read via a HI shadow, registered timer
// interrupt request. Optional prescaler in CTRL[8 +: PRESC_W] when
// MTIMER_PRESCALER_EN is defined.
module mtimer_unit
  import mtimer_unit_pkg::*;
#(
  parameter logic [63:0] CMP_RST = CMP_RST_DEFAULT,
  parameter int unsigned PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tmr_sel,
  input  logic [2:0]  tmr_adr,
  input  logic        tmr_we,
  input  logic        tmr_re,
  input  logic [31:0] tmr_wdata,
  output logic [31:0] tmr_rdata,
  input  logic        csr_mtie,
  output logic        frc_cntr_val_leq
);

  logic               w_wr;
  logic               w_rd;
  logic               w_wr_ctrl;
  logic               w_clr;
  logic               w_ld_lo;
  logic               w_ld_hi;
  logic               w_tick;
  logic [63:0]        w_mtime;
  logic [PRESC_W-1:0] w_presc_val;
  logic [31:0]        w_rd_val;

  logic               r_en;
  logic [63:0]        r_cmp;
  logic [31:0]        r_rdata;
  logic [31:0]        r_shadow;
  logic               r_leq;

  assign w_wr      = tmr_sel & tmr_we;
  assign w_rd      = tmr_sel & tmr_re;
  assign w_wr_ctrl = w_wr & (tmr_adr == OFS_CTRL);
  assign w_clr     = w_wr_ctrl & tmr_wdata[CTRL_CLR];
  assign w_ld_lo   = w_wr & (tmr_adr == OFS_MTIME_LO);
  assign w_ld_hi   = w_wr & (tmr_adr == OFS_MTIME_HI);

`ifdef MTIMER_PRESCALER_EN
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_pcnt;

  assign w_presc_val = r_presc;
  assign w_tick      = r_en & (r_pcnt == r_presc);

  // Prescaler: any CTRL write (including CLR) restarts the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_pcnt  <= '0;
    end else if (w_wr_ctrl) begin
      r_presc <= tmr_wdata[CTRL_PRESC_LSB +: PRESC_W];
      r_pcnt  <= '0;
    end else if (r_en) begin
      r_pcnt <= w_tick ? '0 : r_pcnt + PRESC_W'(1);
    end
  end
`else
  assign w_presc_val = '0;
  assign w_tick      = r_en;
`endif

  mtimer_cnt64 u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_inc     (w_tick),
    .i_ld_lo   (w_ld_lo),
    .i_ld_hi   (w_ld_hi),
    .i_ld_data (tmr_wdata),
    .o_cnt     (w_mtime)
  );

  // Register writes: EN and the two mtimecmp halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en  <= 1'b0;
      r_cmp <= CMP_RST;
    end else if (w_wr) begin
      case (tmr_adr)
        OFS_MTIMECMP_LO: r_cmp[31:0]  <= tmr_wdata;
        OFS_MTIMECMP_HI: r_cmp[63:32] <= tmr_wdata;
        OFS_CTRL:        r_en         <= tmr_wdata[CTRL_EN];
        default:         ;
      endcase
    end
  end

  // Read mux from pre-write state so a same-cycle write is not visible.
  always_comb begin
    w_rd_val = '0;
    case (tmr_adr)
      OFS_MTIME_LO:    w_rd_val = lo_word(w_mtime);
      OFS_MTIME_HI:    w_rd_val = r_shadow;
      OFS_MTIMECMP_LO: w_rd_val = lo_word(r_cmp);
      OFS_MTIMECMP_HI: w_rd_val = hi_word(r_cmp);
      OFS_CTRL:        w_rd_val = 32'({w_presc_val, 6'b0, 1'b0, r_en});
      default:         w_rd_val = '0;
    endcase
  end

  // Registered read data; a LO read snapshots the live HI word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_shadow <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rd_val;
      if (tmr_adr == OFS_MTIME_LO) begin
        r_shadow <= hi_word(w_mtime);
      end
    end
  end

  // Level interrupt request, independent of EN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_leq <= 1'b0;
    end else begin
      r_leq <= csr_mtie & (r_cmp <= w_mtime);
    end
  end

  assign tmr_rdata        = r_rdata;
  assign frc_cntr_val_leq = r_leq;

endmodule

// File: tb/tb_mtimer_unit.sv
// Self-checking bench for mtimer_unit: directed scenarios against fixed
// expectations plus a randomized bus run against a register-level model.
module tb_mtimer_unit;

  logic        clk;
  logic        rst_n;
  logic        tmr_sel;
  logic [2:0]  tmr_adr;
  logic        tmr_we;
  logic        tmr_re;
  logic [31:0] tmr_wdata;
  logic [31:0] tmr_rdata;
  logic        csr_mtie;
  logic        frc_cntr_val_leq;

  int unsigned total;
  int unsigned bad;

  mtimer_unit #(
    .CMP_RST (64'hFFFF_FFFF_FFFF_FFFF),
    .PRESC_W (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tmr_sel          (tmr_sel),
    .tmr_adr          (tmr_adr),
    .tmr_we           (tmr_we),
    .tmr_re           (tmr_re),
    .tmr_wdata        (tmr_wdata),
    .tmr_rdata        (tmr_rdata),
    .csr_mtie         (csr_mtie),
    .frc_cntr_val_leq (frc_cntr_val_leq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural registers updated by the spec rules.
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [7:0]  m_p;
  int unsigned m_phase;
  logic [31:0] m_shadow;
  logic [31:0] m_rdata;
  logic        m_leq;

  always @(posedge clk or negedge rst_n) begin
    logic        wr;
    logic        rd;
    logic        tick;
    logic [63:0] nt;
    if (!rst_n) begin
      m_time   <= 64'd0;
      m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
      m_en     <= 1'b0;
      m_p      <= 8'd0;
      m_phase  <= 0;
      m_shadow <= 32'd0;
      m_rdata  <= 32'd0;
      m_leq    <= 1'b0;
    end else begin
      wr = tmr_sel && tmr_we;
      rd = tmr_sel && tmr_re;
`ifdef MTIMER_PRESCALER_EN
      tick = m_en && ((m_phase % (int'(m_p) + 1)) == int'(m_p));
`else
      tick = m_en;
`endif
      nt = tick ? m_time + 64'd1 : m_time;
      if (wr && tmr_adr == 3'd0) nt = {m_time[63:32], tmr_wdata};
      if (wr && tmr_adr == 3'd1) nt = {tmr_wdata, m_time[31:0]};
      if (wr && tmr_adr == 3'd4 && tmr_wdata[1]) nt = 64'd0;
      m_time <= nt;
      if (wr && tmr_adr == 3'd4) m_phase <= 0;
      else if (m_en) m_phase <= m_phase + 1;
      if (wr && tmr_adr == 3'd2) m_cmp[31:0] <= tmr_wdata;
      if (wr && tmr_adr == 3'd3) m_cmp[63:32] <= tmr_wdata;
      if (wr && tmr_adr == 3'd4) begin
        m_en <= tmr_wdata[0];
`ifdef MTIMER_PRESCALER_EN
        m_p  <= tmr_wdata[15:8];
`endif
      end
      if (rd) begin
        case (tmr_adr)
          3'd0: begin m_rdata <= m_time[31:0]; m_shadow <= m_time[63:32]; end
          3'd1: m_rdata <= m_shadow;
          3'd2: m_rdata <= m_cmp[31:0];
          3'd3: m_rdata <= m_cmp[63:32];
          3'd4: m_rdata <= {16'h0, m_p, 7'h0, m_en};
          default: m_rdata <= 32'd0;
        endcase
      end
      m_leq <= csr_mtie && (m_cmp <= m_time);
    end
  end

  // Bus helpers: called at a negedge, return at the next negedge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    tmr_sel = 1'b1; tmr_we = 1'b1; tmr_adr = a; tmr_wdata = d;
    @(negedge clk);
    tmr_sel = 1'b0; tmr_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    tmr_sel = 1'b1; tmr_re = 1'b1; tmr_adr = a;
    @(negedge clk);
    tmr_sel = 1'b0; tmr_re = 1'b0;
    d = tmr_rdata;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    total++; if (tmr_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h expected %h", tmr_rdata, 32'd0); end
    total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL rst_leq: got %b expected 0", frc_cntr_val_leq); end
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_mtime_lo: got %h expected %h", rd, 32'd0); end
    bus_read(3'd3, rd);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_hi: got %h expected %h", rd, 32'hFFFF_FFFF); end
    bus_read(3'd4, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_ctrl: got %h expected %h", rd, 32'd0); end
    bus_write(3'd5, 32'h1234_5678);
    bus_read(3'd5, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL reserved_read: got %h expected %h", rd, 32'd0); end
    repeat (10) @(negedge clk);
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL stopped_mtime: got %h expected %h", rd, 32'd0); end
  endtask

  task automatic test_count;
    logic [31:0] rd;
    bus_write(3'd4, 32'd1);
    repeat (5) @(negedge clk);
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd5) begin bad++; $display("FAIL count5: got %h expected %h", rd, 32'd5); end
    @(negedge clk);
    total++; if (tmr_rdata !== 32'd5) begin bad++; $display("FAIL rdata_hold: got %h expected %h", tmr_rdata, 32'd5); end
  endtask

  task automatic test_carry;
    logic [31:0] rd;
    bus_write(3'd4, 32'd0);
    bus_write(3'd1, 32'd0);
    bus_write(3'd0, 32'hFFFF_FFFD);
    bus_write(3'd4, 32'd1);
    bus_read(3'd0, rd);
    total++; if (rd !== 32'hFFFF_FFFD) begin bad++; $display("FAIL carry_lo0: got %h expected %h", rd, 32'hFFFF_FFFD); end
    repeat (3) @(negedge clk);
    bus_read(3'd1, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL shadow_hold: got %h expected %h", rd, 32'd0); end
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd2) begin bad++; $display("FAIL carry_lo1: got %h expected %h", rd, 32'd2); end
    bus_read(3'd1, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("FAIL carry_hi: got %h expected %h", rd, 32'd1); end
  endtask

  task automatic test_compare;
    bus_write(3'd4, 32'd0);
    bus_write(3'd1, 32'd0);
    bus_write(3'd0, 32'd0);
    bus_write(3'd3, 32'd0);
    bus_write(3'd2, 32'd20);
    csr_mtie = 1'b1;
    bus_write(3'd4, 32'd1);
    for (int unsigned k = 1; k <= 25; k++) begin
      @(negedge clk);
      total++;
      if (frc_cntr_val_leq !== (k >= 21)) begin
        bad++; $display("FAIL leq_rise k=%0d: got %b expected %b", k, frc_cntr_val_leq, (k >= 21));
      end
    end
    bus_write(3'd2, 32'd100);
    total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL leq_raise_cmp_edge: got %b expected 1", frc_cntr_val_leq); end
    @(negedge clk);
    total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL leq_drop_cmp: got %b expected 0", frc_cntr_val_leq); end
    bus_write(3'd2, 32'd20);
    @(negedge clk);
    total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL leq_rearm: got %b expected 1", frc_cntr_val_leq); end
    csr_mtie = 1'b0;
    @(negedge clk);
    total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL leq_mtie_off: got %b expected 0", frc_cntr_val_leq); end
    csr_mtie = 1'b1;
    bus_write(3'd4, 32'd0);
    repeat (2) @(negedge clk);
    total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL leq_stopped: got %b expected 1", frc_cntr_val_leq); end
    csr_mtie = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap_clr;
    logic [31:0] rd;
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_write(3'd4, 32'd1);
    bus_read(3'd0, rd);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre: got %h expected %h", rd, 32'hFFFF_FFFF); end
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL wrap_lo: got %h expected %h", rd, 32'd0); end
    bus_read(3'd1, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL wrap_hi: got %h expected %h", rd, 32'd0); end
    repeat (4) @(negedge clk);
    bus_write(3'd4, 32'd3);
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL clr_vs_inc: got %h expected %h", rd, 32'd0); end
    bus_read(3'd4, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("FAIL ctrl_readback: got %h expected %h", rd, 32'd1); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bus_write(3'd3, 32'd0);
    bus_write(3'd2, 32'd0);
    csr_mtie = 1'b1;
    bus_read(3'd0, rd);
    total++; if (frc_cntr_val_leq !== 1'b1) begin bad++; $display("FAIL pre_reset_leq: got %b expected 1", frc_cntr_val_leq); end
    rst_n = 1'b0;
    #1;
    total++; if (tmr_rdata !== 32'd0) begin bad++; $display("FAIL async_rdata: got %h expected %h", tmr_rdata, 32'd0); end
    total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL async_leq: got %b expected 0", frc_cntr_val_leq); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(3'd2, rd);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_cmp_lo: got %h expected %h", rd, 32'hFFFF_FFFF); end
    bus_read(3'd3, rd);
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_cmp_hi: got %h expected %h", rd, 32'hFFFF_FFFF); end
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL mid_mtime: got %h expected %h", rd, 32'd0); end
    total++; if (frc_cntr_val_leq !== 1'b0) begin bad++; $display("FAIL mid_leq: got %b expected 0", frc_cntr_val_leq); end
    csr_mtie = 1'b0;
  endtask

`ifdef MTIMER_PRESCALER_EN
  task automatic test_prescaler;
    logic [31:0] rd;
    bus_write(3'd4, 32'd0);
    bus_write(3'd1, 32'd0);
    bus_write(3'd0, 32'd0);
    bus_write(3'd4, 32'h0000_0301);
    repeat (3) @(negedge clk);
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL presc_before: got %h expected %h", rd, 32'd0); end
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("FAIL presc_first: got %h expected %h", rd, 32'd1); end
    bus_write(3'd4, 32'h0000_0301);
    repeat (3) @(negedge clk);
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd1) begin bad++; $display("FAIL presc_restart: got %h expected %h", rd, 32'd1); end
    bus_read(3'd0, rd);
    total++; if (rd !== 32'd2) begin bad++; $display("FAIL presc_second: got %h expected %h", rd, 32'd2); end
    bus_read(3'd4, rd);
    total++; if (rd !== 32'h0000_0301) begin bad++; $display("FAIL presc_ctrl: got %h expected %h", rd, 32'h0000_0301); end
  endtask
`endif

  task automatic test_random;
    for (int unsigned i = 0; i < 600; i++) begin
      int unsigned r;
      logic [2:0]  a;
      r = $urandom_range(0, 99);
      a = 3'($urandom_range(0, 7));
      tmr_adr = a;
      tmr_wdata = $urandom;
      if (r < 30) begin
        tmr_sel = 1'b1; tmr_re = 1'b1;
      end else if (r < 35) begin
        tmr_re = 1'b1; tmr_we = 1'b1;
      end else if (r < 62) begin
        tmr_sel = 1'b1; tmr_we = 1'b1;
        tmr_re = ($urandom_range(0, 3) == 0);
        case (a)
          3'd0: if ($urandom_range(0, 1) == 0) tmr_wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          3'd1: if ($urandom_range(0, 1) == 0) tmr_wdata = 32'($urandom_range(0, 2));
          3'd2: tmr_wdata = m_time[31:0] + 32'($urandom_range(0, 40));
          3'd3: tmr_wdata = m_time[63:32] + 32'($urandom_range(0, 1));
          3'd4: tmr_wdata = {16'h0, 8'($urandom_range(0, 3)), 6'h0,
                             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0)};
          default: ;
        endcase
      end else if (r < 68) begin
        csr_mtie = ~csr_mtie;
      end
      @(negedge clk);
      tmr_sel = 1'b0; tmr_we = 1'b0; tmr_re = 1'b0;
      total++;
      if (tmr_rdata !== m_rdata) begin
        bad++; $display("FAIL rand_rdata i=%0d: got %h expected %h", i, tmr_rdata, m_rdata);
      end
      total++;
      if (frc_cntr_val_leq !== m_leq) begin
        bad++; $display("FAIL rand_leq i=%0d: got %b expected %b", i, frc_cntr_val_leq, m_leq);
      end
    end
    csr_mtie = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    tmr_sel = 1'b0;
    tmr_adr = 3'd0;
    tmr_we = 1'b0;
    tmr_re = 1'b0;
    tmr_wdata = 32'd0;
    csr_mtie = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_count();
    test_carry();
    test_compare();
    test_wrap_clr();
    test_reset_mid();
`ifdef MTIMER_PRESCALER_EN
    test_prescaler();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtimer_unit.md
Name: mtimer_unit

Overview:
- Machine-mode timer peripheral. Holds a 64-bit free-running counter (mtime) and a 64-bit compare register (mtimecmp), both memory-mapped on the CPU I/O bus.
- Drives the level timer-pending signal frc_cntr_val_leq, which the CSR block consumes for MIP.MTIP, mcause code 7 and mepc capture.
- Sits on the I/O bus beside other peripherals. Its output connects directly to the CSR block's timer input.

Parameters:
- CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp, chosen so no interrupt fires out of reset.
- PRESC_W, 8, width of the prescaler register and counter (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tmr_sel  in  1  address decode hit for the timer window; qualifies tmr_we and tmr_re.
- tmr_adr  in  3  word offset [4:2]: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL; 5-7 reserved.
- tmr_we  in  1  write strobe, single cycle.
- tmr_re  in  1  read strobe, single cycle.
- tmr_wdata  in  32  write data.
- tmr_rdata  out  32  registered read data, valid the cycle after tmr_re.
- csr_mtie  in  1  MIE.MTIE from the CSR block.
- frc_cntr_val_leq  out  1  timer interrupt request (level).

Behaviour:
- Reset values:
  - mtime = 0; mtimecmp = CMP_RST; CTRL = 0 (counter stopped).
  - tmr_rdata = 0; HI shadow = 0; frc_cntr_val_leq = 0.
  - With the optional feature: prescaler register = 0, prescaler counter = 0.
- CTRL register:
  - bit0 EN: counter runs only when EN = 1.
  - bit1 CLR: write-1 pulse clears mtime to 0 in the same cycle; reads as 0.
  - All other bits read 0.
- Increment:
  - When EN = 1 and a tick occurs, mtime <= mtime + 1 (full 64-bit add, carry from LO into HI).
  - Wrap: 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
  - Without the optional feature, a tick occurs every clk.
- Writes: when tmr_sel & tmr_we, the addressed 32-bit half is written at the posedge.
  - A bus write to MTIME_LO or MTIME_HI overrides that cycle's increment of the written half. The unwritten half keeps its old value and receives no carry.
  - CLR has priority over an increment in the same cycle.
  - Writes to reserved offsets are ignored.
- Reads: when tmr_sel & tmr_re, tmr_rdata <= the selected value at the posedge, so latency is 1 cycle. tmr_rdata holds its value until the next read.
  - Reading MTIME_LO also latches the current mtime[63:32] into the HI shadow.
  - Reading MTIME_HI returns the shadow, not live mtime. This gives an atomic LO-then-HI read.
  - Reserved offsets read 0.
- Simultaneous tmr_we and tmr_re: the write is performed and the read returns the pre-write value.
- Compare:
  - frc_cntr_val_leq is registered: frc_cntr_val_leq <= csr_mtie & (mtimecmp <= mtime), 64-bit unsigned compare.
  - It stays asserted until software raises mtimecmp, clears mtie, or mtime wraps.
  - The compare does not depend on EN, so a stopped counter at or past compare still requests.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronous reset).

Optional Feature:
- Macro MTIMER_PRESCALER_EN.
- When defined:
  - CTRL[8+PRESC_W-1:8] is a read/write prescaler value P.
  - A PRESC_W-bit counter increments each clk while EN = 1. A tick occurs when counter == P, and the counter then reloads to 0, so mtime advances every P+1 clocks.
  - Writing CTRL resets the prescaler counter to 0.
  - CLR also resets the prescaler counter.
- When undefined: those CTRL bits read 0, writes to them are ignored, and a tick occurs every clk.

Decomposition:
- Shared package (or define header):
  - register word offsets MTIME_LO/HI, MTIMECMP_LO/HI, CTRL;
  - CTRL bit positions EN, CLR, PRESC_LSB;
  - CMP_RST constant.
- One natural sub-module: mtimer_cnt64, holding the 64-bit counter with split-half load, clear and increment-with-carry. The register file, shadow, compare and prescaler stay in the top level.

Test Plan:
- Reset, then read MTIME_LO and MTIMECMP_HI -> rdata 0 and 32'hFFFF_FFFF; frc_cntr_val_leq = 0; mtime stays 0 for 10 cycles (EN = 0).
- Write CTRL = 1, wait 5 cycles, read MTIME_LO -> value 5 (±1 per the documented write/read cycle alignment); the next cycle's rdata is unchanged without a new read.
- Write MTIME_HI = 0, MTIME_LO = 32'hFFFF_FFFE, EN = 1; two cycles later read LO then HI -> LO 0 or 1, HI 1 (carry). Also check that the shadow HI is unchanged by a further increment between the two reads.
- Set csr_mtie = 1, MTIMECMP_HI = 0, MTIMECMP_LO = 20, mtime = 0, EN = 1 -> frc_cntr_val_leq rises exactly one cycle after mtime reaches 20. Writing MTIMECMP_LO = 100 drops it the next cycle; csr_mtie = 0 also drops it.
- mtime = 64'hFFFF_FFFF_FFFF_FFFF with EN = 1 -> next value 0. A CLR write in the same cycle as an increment -> 0. Assert rst_n mid-count -> all outputs 0 and mtimecmp back to all-ones.
- With MTIMER_PRESCALER_EN defined, CTRL = {P = 3, EN = 1} -> mtime increments every 4 clocks. Rewriting CTRL restarts the 4-clock phase.
